// File: rtl/dma_pkg.sv
// Shared definitions for the disk-to-memory DMA engine.
//  - Bus/field widths, register word offsets and block base address.
//  - FSM state constants and the matching dma_state_e enum.
//  - dma_cfg_t: the three live transfer registers, passed between the
//    register file and the engine as a single payload.
package dma_pkg;

    localparam int unsigned MEM_AW  = 15;
    localparam int unsigned DISK_AW = 32;
    localparam int unsigned SIZE_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_AW  = 2;
    localparam int unsigned ST_W    = 3;

    localparam logic [REG_AW-1:0] REG_DISK_ADDR = 2'd0;
    localparam logic [REG_AW-1:0] REG_MEM_ADDR  = 2'd1;
    localparam logic [REG_AW-1:0] REG_T_SIZE    = 2'd2;
    localparam logic [REG_AW-1:0] REG_INIT_TRAN = 2'd3;

    localparam logic [31:0] DMA_BASE = 32'h8000_0000;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_RD_REQ  = 3'd1;
    localparam logic [ST_W-1:0] ST_RD_WAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_WR      = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE    = 3'd4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_RD_REQ  = ST_RD_REQ,
        S_RD_WAIT = ST_RD_WAIT,
        S_WR      = ST_WR,
        S_DONE    = ST_DONE
    } dma_state_e;

    typedef struct packed {
        logic [DISK_AW-1:0] disk_addr;
        logic [MEM_AW-1:0]  mem_addr;
        logic [SIZE_W-1:0]  t_size;
    } dma_cfg_t;

endpackage

// File: rtl/dma_regfile.sv
// Configuration registers of the DMA engine.
// Ports:
//  clk, rst_n     clock, async active-low reset
//  reg_sel/reg_wr/reg_addr/reg_wdata   CPU register write/read port
//  reg_rdata      combinational read data selected by reg_addr
//  busy           engine busy (locks out writes and starts)
//  upd_en/upd_cfg engine write-back of advanced addresses/count
//  cfg            live register contents
//  start_pulse    1-cycle registered start request
module dma_regfile
    import dma_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_sel,
    input  logic              reg_wr,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    input  logic              busy,
    input  logic              upd_en,
    input  dma_cfg_t          upd_cfg,
    output dma_cfg_t          cfg,
    output logic              start_pulse
);

    dma_cfg_t cfg_q;
    dma_cfg_t cfg_d;
    logic     start_q;
    logic     start_d;
    logic     wr_ok;
    logic     unused_wdata_c;

    // Bit 1 of write data has no destination in any register.
    assign unused_wdata_c = reg_wdata[1];

    // A start waiting to be taken counts as busy so it cannot be reprogrammed under it.
    assign wr_ok = reg_sel & reg_wr & ~busy & ~start_q;

    // Register update: engine write-back wins; CPU writes only when idle.
    always_comb begin : reg_next
        cfg_d   = cfg_q;
        start_d = 1'b0;
        if (upd_en) begin
            cfg_d = upd_cfg;
        end else if (wr_ok) begin
            case (reg_addr)
                REG_DISK_ADDR: cfg_d.disk_addr = {reg_wdata[DISK_AW-1:2], 2'b00};
                REG_MEM_ADDR:  cfg_d.mem_addr  = {reg_wdata[MEM_AW-1:2], 2'b00};
                REG_T_SIZE:    cfg_d.t_size    = {reg_wdata[SIZE_W-1:2], 2'b00};
                REG_INIT_TRAN: start_d         = reg_wdata[0];
                default:       cfg_d           = cfg_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : reg_flops
        if (!rst_n) begin
            cfg_q   <= '0;
            start_q <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            start_q <= start_d;
        end
    end

    // Read mux: live register values, INIT_TRAN reports busy.
    always_comb begin : rdata_mux
        reg_rdata = '0;
        case (reg_addr)
            REG_DISK_ADDR: reg_rdata = DATA_W'(cfg_q.disk_addr);
            REG_MEM_ADDR:  reg_rdata = DATA_W'(cfg_q.mem_addr);
            REG_T_SIZE:    reg_rdata = DATA_W'(cfg_q.t_size);
            REG_INIT_TRAN: reg_rdata = DATA_W'(busy);
            default:       reg_rdata = '0;
        endcase
    end

    assign cfg         = cfg_q;
    assign start_pulse = start_q;

endmodule

// File: rtl/dma_disk_ctrl.sv
// Disk-to-main-memory DMA engine: copies one 32-bit word at a time from
// disk to memory through a one-word buffer, then pulses done_irq.
// Ports:
//  clk, rst_n                      clock, async active-low reset
//  reg_sel/reg_wr/reg_addr/reg_wdata/reg_rdata   CPU register port
//  disk_rd_req/disk_rd_addr        1-cycle disk read request + word address
//  disk_rd_vld/disk_rd_data        disk read return
//  mem_wr_req/addr/data, mem_wr_gnt memory write, held until granted
//  busy                            transfer in progress (incl. DONE cycle)
//  done_irq                        1-cycle completion pulse
module dma_disk_ctrl
    import dma_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reg_sel,
    input  logic               reg_wr,
    input  logic [REG_AW-1:0]  reg_addr,
    input  logic [DATA_W-1:0]  reg_wdata,
    output logic [DATA_W-1:0]  reg_rdata,
    output logic               disk_rd_req,
    output logic [DISK_AW-1:0] disk_rd_addr,
    input  logic               disk_rd_vld,
    input  logic [DATA_W-1:0]  disk_rd_data,
    output logic               mem_wr_req,
    output logic [MEM_AW-1:0]  mem_wr_addr,
    output logic [DATA_W-1:0]  mem_wr_data,
    input  logic               mem_wr_gnt,
    output logic               busy,
    output logic               done_irq
);

    localparam logic [DISK_AW-1:0] DISK_STEP = DISK_AW'(4);
    localparam logic [MEM_AW-1:0]  MEM_STEP  = MEM_AW'(4);
    localparam logic [SIZE_W-1:0]  SIZE_STEP = SIZE_W'(4);

    dma_state_e        state_q;
    dma_state_e        state_d;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] buf_d;
    logic              disk_rd_req_q;
    logic              disk_rd_req_d;
    logic              mem_wr_req_q;
    logic              mem_wr_req_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_irq_q;
    logic              done_irq_d;

    dma_cfg_t          cfg;
    dma_cfg_t          upd_cfg;
    logic              upd_en;
    logic              start_pulse;

    dma_regfile u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_sel     (reg_sel),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .busy        (busy_q),
        .upd_en      (upd_en),
        .upd_cfg     (upd_cfg),
        .cfg         (cfg),
        .start_pulse (start_pulse)
    );

    // Advanced register values applied when a memory write is granted; address wraps are natural.
    always_comb begin : counter_next
        upd_cfg           = cfg;
        upd_cfg.disk_addr = cfg.disk_addr + DISK_STEP;
        upd_cfg.mem_addr  = cfg.mem_addr + MEM_STEP;
        upd_cfg.t_size    = cfg.t_size - SIZE_STEP;
    end

    // Next state, buffer capture, and next values of the registered outputs.
    always_comb begin : fsm_next
        state_d = state_q;
        buf_d   = buf_q;
        upd_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    state_d = (cfg.t_size == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (disk_rd_vld) begin
                    buf_d   = disk_rd_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (mem_wr_gnt) begin
                    upd_en  = 1'b1;
                    state_d = (upd_cfg.t_size == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs follow the state being entered so they are flop-driven.
        disk_rd_req_d = (state_d == S_RD_REQ);
        mem_wr_req_d  = (state_d == S_WR);
        busy_d        = (state_d != S_IDLE);
        done_irq_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_flops
        if (!rst_n) begin
            state_q       <= S_IDLE;
            buf_q         <= '0;
            disk_rd_req_q <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_irq_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            disk_rd_req_q <= disk_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            busy_q        <= busy_d;
            done_irq_q    <= done_irq_d;
        end
    end

    assign disk_rd_req  = disk_rd_req_q;
    assign disk_rd_addr = cfg.disk_addr;
    assign mem_wr_req   = mem_wr_req_q;
    assign mem_wr_addr  = cfg.mem_addr;
    assign mem_wr_data  = buf_q;
    assign busy         = busy_q;
    assign done_irq     = done_irq_q;

endmodule
